// File: rtl/button_counter.sv
// Two push buttons (UP/DOWN) synchronized, debounced and edge-detected.
// Each accepted press steps an 8-bit count up or down.

module button_debounce #(
  parameter int DEBOUNCE_BITS = 16,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic accept,
  output logic pulse,
  output logic held
);

  localparam logic RELEASED = (ACTIVE_LOW != 0);
  localparam logic [DEBOUNCE_BITS-1:0] COUNT_MAX = {DEBOUNCE_BITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t                   state;
  logic [DEBOUNCE_BITS-1:0] counter;
  logic                     sync_a;
  logic                     sync_b;
  logic                     level;

  // Internally a pressed button always reads as 1.
  assign level = sync_b ^ RELEASED;

  // Combinational so the count register can step on the same edge the pulse rises.
  assign accept = (state == PRESS_WAIT) && level && (counter == COUNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a  <= RELEASED;
      sync_b  <= RELEASED;
      state   <= IDLE;
      counter <= '0;
      pulse   <= 1'b0;
      held    <= 1'b0;
    end else begin
      sync_a <= pin;
      sync_b <= sync_a;
      pulse  <= 1'b0;
      case (state)
        IDLE: begin
          held <= 1'b0;
          if (level) begin
            state   <= PRESS_WAIT;
            counter <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!level) begin
            state <= IDLE;
          end else if (counter == COUNT_MAX) begin
            state <= PRESSED;
            pulse <= 1'b1;
            held  <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        PRESSED: begin
          held <= 1'b1;
          if (!level) begin
            state   <= RELEASE_WAIT;
            counter <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (level) begin
            state <= PRESSED;
          end else if (counter == COUNT_MAX) begin
            state <= IDLE;
            held  <= 1'b0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

module button_counter #(
  parameter int         DEBOUNCE_BITS = 16,
  parameter int         ACTIVE_LOW    = 1,
  parameter logic [7:0] RESET_COUNT   = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [7:0] count,
  output logic       up_pulse,
  output logic       dn_pulse,
  output logic       up_held,
  output logic       dn_held
);

  // Index 0 = UP, index 1 = DOWN.
  logic [1:0] pins;
  logic [1:0] accepts;
  logic [1:0] pulses;
  logic [1:0] helds;

  assign pins = {btn_dn, btn_up};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS),
        .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .pin   (pins[gi]),
        .accept(accepts[gi]),
        .pulse (pulses[gi]),
        .held  (helds[gi])
      );
    end
  endgenerate

  assign up_pulse = pulses[0];
  assign dn_pulse = pulses[1];
  assign up_held  = helds[0];
  assign dn_held  = helds[1];

  // Simultaneous presses cancel; wrap-around is the natural 8-bit overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RESET_COUNT;
    end else begin
      case (accepts)
        2'b01:   count <= count + 8'd1;
        2'b10:   count <= count - 8'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_button_counter.sv
// Randomized and directed stimulus for button_counter, checked every cycle
// against a run-length debounce model kept in the bench.

module tb_button_counter;

  localparam int N        = 3;
  localparam int QUALIFY  = (1 << N) + 1;  // consecutive stable FSM samples to flip held

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic [7:0] count_a, count_b;
  logic       up_pulse_a, dn_pulse_a, up_held_a, dn_held_a;
  logic       up_pulse_b, dn_pulse_b, up_held_b, dn_held_b;

  int checks = 0;
  int errors = 0;

  // Model state: per-button sampled-pin pipeline, debounced level and run length.
  logic       s1_m[2], s2_m[2], held_m[2], pulse_m[2];
  int         run_m[2];
  logic [7:0] count_ma, count_mb;

  always #5 clk = ~clk;

  button_counter #(.DEBOUNCE_BITS(N), .ACTIVE_LOW(1), .RESET_COUNT(8'd0)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
    .count(count_a), .up_pulse(up_pulse_a), .dn_pulse(dn_pulse_a),
    .up_held(up_held_a), .dn_held(dn_held_a)
  );

  button_counter #(.DEBOUNCE_BITS(N), .ACTIVE_LOW(1), .RESET_COUNT(8'd254)) dut_wrap (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
    .count(count_b), .up_pulse(up_pulse_b), .dn_pulse(dn_pulse_b),
    .up_held(up_held_b), .dn_held(dn_held_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model reacts to the inputs sampled at this edge; buttons are active-low pins.
  task automatic model_edge(input logic r, input logic pu, input logic pd);
    logic pressed[2];
    logic lvl;
    pressed[0] = pu;
    pressed[1] = pd;
    if (r) begin
      for (int b = 0; b < 2; b++) begin
        s1_m[b] = 1'b0; s2_m[b] = 1'b0; held_m[b] = 1'b0;
        pulse_m[b] = 1'b0; run_m[b] = 0;
      end
      count_ma = 8'd0;
      count_mb = 8'd254;
    end else begin
      for (int b = 0; b < 2; b++) begin
        lvl = s2_m[b];
        s2_m[b] = s1_m[b];
        s1_m[b] = pressed[b];
        pulse_m[b] = 1'b0;
        if (lvl != held_m[b]) begin
          run_m[b]++;
          if (run_m[b] == QUALIFY) begin
            held_m[b] = lvl;
            pulse_m[b] = lvl;
            run_m[b] = 0;
          end
        end else begin
          run_m[b] = 0;
        end
      end
      if (pulse_m[0] && !pulse_m[1]) begin
        count_ma++; count_mb++;
      end else if (pulse_m[1] && !pulse_m[0]) begin
        count_ma--; count_mb--;
      end
    end
  endtask

  task automatic step(input logic r, input logic pu, input logic pd);
    rst    = r;
    btn_up = ~pu;
    btn_dn = ~pd;
    @(posedge clk);
    model_edge(r, pu, pd);
    #1;
    check("count",    count_a,    count_ma);
    check("up_pulse", up_pulse_a, pulse_m[0]);
    check("dn_pulse", dn_pulse_a, pulse_m[1]);
    check("up_held",  up_held_a,  held_m[0]);
    check("dn_held",  dn_held_a,  held_m[1]);
    check("count_w",  count_b,    count_mb);
    check("up_pulse_w", up_pulse_b, pulse_m[0]);
    check("dn_pulse_w", dn_pulse_b, pulse_m[1]);
  endtask

  task automatic hold(input logic pu, input logic pd, input int n);
    for (int i = 0; i < n; i++) step(1'b0, pu, pd);
  endtask

  initial begin
    int up_edges;
    logic pu, pd;

    // Reset with both buttons pressed, then keep them held
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    hold(1'b1, 1'b1, 15);
    hold(1'b0, 1'b0, 15);

    // Clean UP press; count the pulses independently
    up_edges = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (up_pulse_a) up_edges++;
    end
    hold(1'b0, 1'b0, 15);
    check("one_pulse", 8'(up_edges), 8'd1);
    check("count_after_press", count_a, 8'd1);

    // Bounce on DOWN, then a qualifying press
    for (int k = 0; k < 4; k++) begin
      hold(1'b0, 1'b1, 5);
      hold(1'b0, 1'b0, 2);
    end
    hold(1'b0, 1'b0, 10);
    check("bounce_no_change", count_a, 8'd1);
    hold(1'b0, 1'b1, 12);
    hold(1'b0, 1'b0, 15);

    // Repeated UP presses drive the wrap instance through 255 -> 0
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 1'b0, 12);
      hold(1'b0, 1'b0, 15);
    end

    // Simultaneous press
    hold(1'b1, 1'b1, 14);
    hold(1'b0, 1'b0, 15);

    // Reset in the middle of qualifying an UP press
    hold(1'b1, 1'b0, 5);
    step(1'b1, 1'b1, 1'b0);
    hold(1'b1, 1'b0, 15);
    check("mid_reset_count", count_a, 8'd1);
    hold(1'b0, 1'b0, 15);

    // Random segments of stable levels of varying length, with occasional reset
    for (int seg = 0; seg < 80; seg++) begin
      pu = 1'($urandom_range(0, 1));
      pd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) step(1'b1, pu, pd);
      hold(pu, pd, $urandom_range(1, 14));
    end
    hold(1'b0, 1'b0, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
